// File: rtl/gb_apu_pkg.sv
// Shared APU types and constants used by the channel-1 sweep logic.
package gb_apu_pkg;

    typedef logic [10:0] freq_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHECK   = 2'd1,
        CALC    = 2'd2,
        RECHECK = 2'd3
    } sweep_state_t;

    localparam freq_t FREQ_MAX = 11'd2047;

endpackage

// File: rtl/gb_sweep_calc.sv
// Combinational sweep calculation: shadow +/- (shadow >> shift) with overflow flag.
module gb_sweep_calc
    import gb_apu_pkg::*;
(
    input  logic [10:0] shadow,
    input  logic [2:0]  shift,
    input  logic        negate,
    output logic [10:0] sum,
    output logic        overflow
);

    logic [10:0] delta;
    logic [11:0] sum_wide;

    // delta never exceeds shadow, so the subtract path cannot wrap below zero
    always_comb begin
        delta    = shadow >> shift;
        sum_wide = negate ? ({1'b0, shadow} - {1'b0, delta})
                          : ({1'b0, shadow} + {1'b0, delta});
        sum      = sum_wide[10:0];
        overflow = sum_wide > {1'b0, FREQ_MAX};
    end

endmodule

// File: rtl/gb_sweep_unit.sv
// Channel-1 frequency sweep: shadow frequency, sweep timer and the
// check / calculate / recheck sequence with write-back and disable strobes.
//
// state   | meaning
// IDLE    | waiting for trigger or sweep_clk; timer ticks here
// CHECK   | overflow check right after trigger, no write-back
// CALC    | sweep step: write back sum unless it overflows
// RECHECK | overflow check on the freshly written shadow, no write-back
module gb_sweep_unit
    import gb_apu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        sweep_clk,
    input  logic        trigger,
    input  logic [2:0]  sweep_period,
    input  logic        sweep_negate,
    input  logic [2:0]  sweep_shift,
    input  logic [10:0] freq_in,
    output logic [10:0] freq_out,
    output logic        freq_wr,
    output logic        ch_disable,
    output logic        sweep_en
);

    freq_t        shadow;
    logic [2:0]   timer;
    logic         neg_used;
    sweep_state_t state;

    freq_t        calc_sum;
    logic         calc_ovf;
    logic         quirk;
    logic         timer_tick;
    logic         timer_exp;

    gb_sweep_calc u_calc (
        .shadow   (shadow),
        .shift    (sweep_shift),
        .negate   (sweep_negate),
        .sum      (calc_sum),
        .overflow (calc_ovf)
    );

    // Trigger beats sweep_clk; a timer value of 0 behaves as 8 via 3-bit wrap.
    always_comb begin
        quirk      = neg_used && !sweep_negate;
        timer_tick = (state == IDLE) && sweep_clk && !trigger;
        timer_exp  = timer_tick && (timer == 3'd1);
    end

    // Sweep state, timer and registered output strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow     <= '0;
            timer      <= '0;
            neg_used   <= 1'b0;
            sweep_en   <= 1'b0;
            freq_out   <= '0;
            freq_wr    <= 1'b0;
            ch_disable <= 1'b0;
            state      <= IDLE;
        end else begin
            freq_wr    <= 1'b0;
            ch_disable <= 1'b0;

            // The timer runs regardless of sweep_en or the negate quirk.
            if (timer_tick) begin
                timer <= timer_exp ? sweep_period : timer - 3'd1;
            end

            if (trigger) begin
                shadow   <= freq_in;
                timer    <= sweep_period;
                sweep_en <= (sweep_period != 3'd0) || (sweep_shift != 3'd0);
                neg_used <= 1'b0;
                state    <= (sweep_shift != 3'd0) ? CHECK : IDLE;
            end else if (quirk) begin
                // Leaving negate mode after a negate calc kills the channel
                // and overrides any step in flight.
                ch_disable <= 1'b1;
                sweep_en   <= 1'b0;
                neg_used   <= 1'b0;
                state      <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (timer_exp && sweep_en && (sweep_period != 3'd0)) begin
                            state <= CALC;
                        end
                    end
                    CHECK, RECHECK: begin
                        if (sweep_negate) neg_used <= 1'b1;
                        if (calc_ovf) begin
                            ch_disable <= 1'b1;
                            sweep_en   <= 1'b0;
                        end
                        state <= IDLE;
                    end
                    CALC: begin
                        if (sweep_negate) neg_used <= 1'b1;
                        if (calc_ovf) begin
                            ch_disable <= 1'b1;
                            sweep_en   <= 1'b0;
                            state      <= IDLE;
                        end else if (sweep_shift != 3'd0) begin
                            shadow   <= calc_sum;
                            freq_out <= calc_sum;
                            freq_wr  <= 1'b1;
                            state    <= RECHECK;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
